// File: rtl/arith_seq.sv
// arith_seq: arithmetic-unit sequencer for ADD, SUB and MUL.
// It fetches two operands over a req/ack memory handshake, drives the AU
// micro-strobes, and stores the result from AU reg C to addr2.
// Optional build macro ARITH_SEQ_TIMEOUT_EN adds a handshake watchdog
// that gives up after MEM_TIMEOUT cycles without an ack.
module arith_seq #(
  parameter int unsigned MUL_STEPS   = 30,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_i,
  input  logic [1:0] op_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ovf_o,
  output logic       err_o,
  output logic       mem_rd_req_o,
  output logic       mem_wr_req_o,
  output logic       mem_addr_sel_o,
  input  logic       mem_ack_i,
  input  logic       carry_out_from_au,
  input  logic       reg_c30_from_au,
  output logic       do_mem_to_c_to_au,
  output logic       do_move_c_to_a_to_au,
  output logic       do_move_c_to_b_to_au,
  output logic       do_clear_b_to_au,
  output logic       do_not_b_to_au,
  output logic       do_sum_to_au,
  output logic       do_right_shift_bc_to_au,
  output logic       do_move_b_to_c_to_au
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD1, S_MV_A, S_CLR_B, S_LD2, S_MV_B, S_NOT_B,
    S_SUM, S_M_ADD, S_M_SHR, S_MV_BC, S_ST, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             cnt_done;

`ifdef ARITH_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  assign cnt_done = (cnt_q == CNT_W'(MUL_STEPS));

  // State and status registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ARITH_SEQ_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef ARITH_SEQ_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Next-state, step counter and ovf/err status.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = op_e'(op_i);
          cnt_d = '0;
          ovf_d = 1'b0;
          err_d = (op_e'(op_i) == OP_ILL);
          state_d = (op_e'(op_i) == OP_ILL) ? S_DONE : S_LD1;
        end
      end
      S_LD1:   if (mem_ack_i) state_d = S_MV_A;
      S_MV_A:  state_d = (op_q == OP_MUL) ? S_CLR_B : S_LD2;
      S_CLR_B: state_d = S_LD2;
      S_LD2:   if (mem_ack_i) state_d = (op_q == OP_MUL) ? S_M_ADD : S_MV_B;
      S_MV_B:  state_d = (op_q == OP_SUB) ? S_NOT_B : S_SUM;
      S_NOT_B: state_d = S_SUM;
      S_SUM: begin
        ovf_d   = (op_q == OP_SUB) ? ~carry_out_from_au : carry_out_from_au;
        state_d = S_MV_BC;
      end
      // M_ADD doubles as the loop-exit test: after the last shift it is
      // visited once more with the count at MUL_STEPS and issues no strobe.
      S_M_ADD: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = S_MV_BC;
        end else begin
          state_d = S_M_SHR;
        end
      end
      S_M_SHR: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_M_ADD;
      end
      S_MV_BC: state_d = S_ST;
      S_ST:    if (mem_ack_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef ARITH_SEQ_TIMEOUT_EN
    // Watchdog overrides the wait states: give up and report an error.
    wait_d = '0;
    if ((state_q == S_LD1 || state_q == S_LD2 || state_q == S_ST) && !mem_ack_i) begin
      if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
`endif
  end

  // Handshake, status and AU strobe decode from the current state.
  always_comb begin
    busy_o                  = (state_q != S_IDLE);
    done_o                  = (state_q == S_DONE);
    ovf_o                   = ovf_q;
    err_o                   = err_q;
    mem_rd_req_o            = (state_q == S_LD1) || (state_q == S_LD2);
    mem_wr_req_o            = (state_q == S_ST);
    mem_addr_sel_o          = (state_q == S_LD2) || (state_q == S_ST);
    do_mem_to_c_to_au       = ((state_q == S_LD1) || (state_q == S_LD2)) && mem_ack_i;
    do_move_c_to_a_to_au    = (state_q == S_MV_A);
    do_move_c_to_b_to_au    = (state_q == S_MV_B);
    do_clear_b_to_au        = (state_q == S_CLR_B);
    do_not_b_to_au          = (state_q == S_NOT_B);
    do_sum_to_au            = (state_q == S_SUM) ||
                              ((state_q == S_M_ADD) && reg_c30_from_au && !cnt_done);
    do_right_shift_bc_to_au = (state_q == S_M_SHR);
    do_move_b_to_c_to_au    = (state_q == S_MV_BC);
  end

endmodule
